// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 6502C external bus.
// Decodes the CPU address bus into a RAM window, serves reads after a
// programmable number of RDY-low wait states, accepts zero-wait writes and
// blocks writes into a write-protected offset range with a one-cycle error
// pulse.
module cpu_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  RO_LO       = 8'hF0,
  parameter logic [7:0]  RO_HI       = 8'hFF
) (
  input  logic        clock,
  input  logic        RES_L,
  input  logic [15:0] ab,
  input  logic [7:0]  db_in,
  input  logic        rw,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic        rdy,
  output logic        hit,
  output logic        wp_err
);

  localparam int unsigned Depth    = 1 << ADDR_BITS;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);
  localparam logic [15:0] RoLoExt  = {8'h00, RO_LO};
  localparam logic [15:0] RoHiExt  = {8'h00, RO_HI};
  // An inverted range disables protection entirely.
  localparam logic        RoEnable = (RO_LO <= RO_HI);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StData
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_cnt_next;
  logic [ADDR_BITS-1:0] r_offset;
  logic [ADDR_BITS-1:0] w_offset;
  logic [ADDR_BITS-1:0] w_rd_offset;
  logic [15:0]          w_off_ext;
  logic [7:0]           r_db_out;
  logic                 r_wp_err;
  logic [7:0]           r_mem [Depth];

  logic w_accept;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ro;
  logic w_wr_en;
  logic w_wp_block;
  logic w_load_data;

  // Address decode: window select and byte offset within the window.
  assign hit       = (ab[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign w_offset  = ab[ADDR_BITS-1:0];
  assign w_off_ext = {{(16 - ADDR_BITS){1'b0}}, w_offset};
  assign w_ro      = RoEnable && (w_off_ext >= RoLoExt) && (w_off_ext <= RoHiExt);

  // The bus is only sampled outside WAIT; during WAIT ab/rw are ignored.
  assign w_accept   = (r_state != StWait);
  assign w_rd_acc   = w_accept & hit & rw;
  assign w_wr_acc   = w_accept & hit & ~rw;
  assign w_wp_block = w_wr_acc & w_ro;
  // Gate on RES_L so an edge during reset cannot disturb RAM contents.
  assign w_wr_en    = RES_L & w_wr_acc & ~w_ro;

  // Read data is captured on the edge that enters DATA; a WAIT exit uses the
  // latched offset, a zero-wait read uses the live offset.
  assign w_load_data = (w_state_next == StData);
  assign w_rd_offset = (r_state == StWait) ? r_offset : w_offset;

  // State register.
  always_ff @(posedge clock or negedge RES_L) begin
    if (!RES_L) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      StIdle, StData: begin
        if (w_rd_acc) begin
          if (WAIT_STATES == 0) begin
            w_state_next = StData;
          end else begin
            w_state_next    = StWait;
            w_wait_cnt_next = WaitLoad;
          end
        end else begin
          // Writes and misses both leave the bus idle.
          w_state_next = StIdle;
        end
      end
      StWait: begin
        w_wait_cnt_next = r_wait_cnt - 4'd1;
        if (r_wait_cnt <= 4'd1) begin
          w_state_next = StData;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output decode from the current state and the datapath registers.
  always_comb begin
    rdy    = (r_state != StWait);
    db_oe  = (r_state == StData);
    db_out = r_db_out;
    wp_err = r_wp_err;
  end

  // Datapath registers: latched offset, wait counter, read data, error pulse.
  always_ff @(posedge clock or negedge RES_L) begin
    if (!RES_L) begin
      r_offset   <= '0;
      r_wait_cnt <= 4'd0;
      r_db_out   <= 8'h00;
      r_wp_err   <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_next;
      r_wp_err   <= w_wp_block;
      if (w_rd_acc) begin
        r_offset <= w_offset;
      end
      if (w_load_data) begin
        r_db_out <= r_mem[w_rd_offset];
      end
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[w_offset] <= db_in;
    end
  end

  // A WAIT state always has at least one wait cycle left to count.
  a_wait_cnt_nonzero : assert property (@(posedge clock) disable iff (!RES_L)
    (r_state == StWait) |-> (r_wait_cnt != 4'd0));

  // Data is never presented while the CPU is stalled.
  a_oe_implies_rdy : assert property (@(posedge clock) disable iff (!RES_L)
    db_oe |-> rdy);

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: four instances with different wait-state
// counts share one CPU bus. A table of bus cycles is applied; a scoreboard
// queue holds the read data each instance owes and when it is due.
module tb_cpu_bus_responder;

  localparam int NDut = 4;

  function automatic int ws_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  logic        clock = 1'b0;
  logic        RES_L = 1'b1;
  logic [15:0] ab    = 16'h0100;
  logic [7:0]  db_in = 8'h00;
  logic        rw    = 1'b1;

  logic [7:0] db_out [NDut];
  logic       db_oe  [NDut];
  logic       rdy    [NDut];
  logic       hit    [NDut];
  logic       wp_err [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    cpu_bus_responder #(
      .BASE_ADDR  (16'h0000),
      .ADDR_BITS  (8),
      .WAIT_STATES(ws_of(g)),
      .RO_LO      (8'hF0),
      .RO_HI      (8'hFF)
    ) u_dut (
      .clock (clock),
      .RES_L (RES_L),
      .ab    (ab),
      .db_in (db_in),
      .rw    (rw),
      .db_out(db_out[g]),
      .db_oe (db_oe[g]),
      .rdy   (rdy[g]),
      .hit   (hit[g]),
      .wp_err(wp_err[g])
    );
  end

  always #5 clock = ~clock;

  // Expected-read scoreboard: mode 0 = equal, 1 = must differ, 2 = any value.
  typedef struct {
    int         d;
    int         due;
    logic [7:0] data;
    int         mode;
  } rd_item_t;

  typedef struct {
    logic [15:0] a;
    logic        r;
    logic [7:0]  wd;
    logic        exp_hit;
  } vec_t;

  rd_item_t sb_q [$];
  vec_t     vecs [$];

  logic [7:0] sh_mem     [NDut][256];
  logic       sh_known   [NDut][256];
  logic [7:0] sh_forbid  [NDut][256];
  logic       sh_has_fbd [NDut][256];
  int         next_acc   [NDut];
  int         stall_from [NDut];
  int         stall_to   [NDut];
  int         wp_due     [NDut];

  int edge_n   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input int d, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge%0d: got %b want %b", name, d, edge_n, act, exp);
    end
  endtask

  task automatic chk8(input string name, input int d, input logic [7:0] act,
                      input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge%0d: got %h want %h", name, d, edge_n, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input int d, input logic [7:0] act,
                        input logic [7:0] bad);
    n_checks++;
    if (act === bad || $isunknown(act)) begin
      n_fail++;
      $display("FAIL %s dut%0d edge%0d: got %h want anything but %h", name, d, edge_n, act,
               bad);
    end
  endtask

  function automatic void add(input logic [15:0] a, input logic r, input logic [7:0] wd,
                              input logic h);
    vec_t v;
    v.a = a; v.r = r; v.wd = wd; v.exp_hit = h;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(16'h0100, 1'b1, 8'h00, 1'b0);
  endfunction

  function automatic void model_clear();
    sb_q.delete();
    for (int d = 0; d < NDut; d++) begin
      next_acc[d]   = 0;
      stall_from[d] = 0;
      stall_to[d]   = -1;
      wp_due[d]     = -1;
    end
  endfunction

  // Predict the effect of the bus values currently driven, sampled at the next edge.
  function automatic void model_sample();
    int         e;
    int         w;
    logic       h;
    logic [7:0] off;
    rd_item_t   it;
    e   = edge_n + 1;
    h   = (ab[15:8] == 8'h00);
    off = ab[7:0];
    for (int d = 0; d < NDut; d++) begin
      w = ws_of(d);
      if (h && e >= next_acc[d]) begin
        if (rw) begin
          it.d   = d;
          it.due = e + w;
          if (sh_known[d][off]) begin
            it.mode = 0; it.data = sh_mem[d][off];
          end else if (sh_has_fbd[d][off]) begin
            it.mode = 1; it.data = sh_forbid[d][off];
          end else begin
            it.mode = 2; it.data = 8'h00;
          end
          sb_q.push_back(it);
          stall_from[d] = e;
          stall_to[d]   = e + w - 1;
          next_acc[d]   = e + w + 1;
        end else begin
          if (off >= 8'hF0) begin
            wp_due[d] = e;
            if (!sh_known[d][off]) begin
              sh_has_fbd[d][off] = 1'b1;
              sh_forbid[d][off]  = db_in;
            end
          end else begin
            sh_mem[d][off]   = db_in;
            sh_known[d][off] = 1'b1;
          end
          next_acc[d] = e + 1;
        end
      end
    end
  endfunction

  // Compare every instance against the model, away from the active edge.
  task automatic check_all();
    int idx;
    for (int d = 0; d < NDut; d++) begin
      chk1("rdy", d, rdy[d], !(edge_n >= stall_from[d] && edge_n <= stall_to[d]));
      chk1("wp_err", d, wp_err[d], wp_due[d] == edge_n);
      idx = -1;
      foreach (sb_q[i]) if (idx < 0 && sb_q[i].d == d) idx = i;
      if (idx >= 0 && sb_q[idx].due == edge_n) begin
        chk1("db_oe_data", d, db_oe[d], 1'b1);
        if (sb_q[idx].mode == 0) chk8("db_out", d, db_out[d], sb_q[idx].data);
        else if (sb_q[idx].mode == 1) chk_ne("db_out_protected", d, db_out[d], sb_q[idx].data);
        sb_q.delete(idx);
      end else begin
        chk1("db_oe_idle", d, db_oe[d], 1'b0);
      end
    end
  endtask

  // One bus cycle: drive at the falling edge, check after the next rising edge.
  task automatic step(input logic [15:0] a, input logic r, input logic [7:0] wd,
                      input logic h);
    ab = a; rw = r; db_in = wd;
    #1;
    for (int d = 0; d < NDut; d++) chk1("hit", d, hit[d], h);
    model_sample();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    check_all();
  endtask

  // Asynchronous reset: outputs must settle with no clock edge.
  task automatic reset_pulse();
    ab = 16'h0100; rw = 1'b1; db_in = 8'h00;
    RES_L = 1'b0;
    #1;
    for (int d = 0; d < NDut; d++) begin
      chk1("rst_rdy", d, rdy[d], 1'b1);
      chk1("rst_db_oe", d, db_oe[d], 1'b0);
      chk8("rst_db_out", d, db_out[d], 8'h00);
      chk1("rst_wp_err", d, wp_err[d], 1'b0);
    end
    model_clear();
    repeat (2) begin
      @(posedge clock);
      edge_n++;
    end
    @(negedge clock);
    check_all();
    RES_L = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < NDut; d++) begin
      for (int i = 0; i < 256; i++) begin
        sh_mem[d][i] = 8'h00; sh_known[d][i] = 1'b0;
        sh_forbid[d][i] = 8'h00; sh_has_fbd[d][i] = 1'b0;
      end
    end
    model_clear();

    // Vector table: preload, wait-state read, protection, miss, streaming, RAW.
    add(16'h0000, 1'b0, 8'h01, 1'b1);
    add(16'h0001, 1'b0, 8'h02, 1'b1);
    add(16'h0002, 1'b0, 8'h03, 1'b1);
    add(16'h0003, 1'b0, 8'h04, 1'b1);
    add(16'h0010, 1'b0, 8'h3C, 1'b1);
    add(16'h0010, 1'b1, 8'h00, 1'b1); idle(4);
    add(16'h00F5, 1'b0, 8'hAA, 1'b1);
    add(16'h00F5, 1'b1, 8'h00, 1'b1); idle(4);
    add(16'h00EF, 1'b0, 8'h77, 1'b1);
    add(16'h00EF, 1'b1, 8'h00, 1'b1); idle(4);
    add(16'h0100, 1'b0, 8'hFF, 1'b0); idle(1);
    add(16'hFF10, 1'b1, 8'h00, 1'b0); idle(1);
    add(16'h0000, 1'b1, 8'h00, 1'b1);
    add(16'h0001, 1'b1, 8'h00, 1'b1);
    add(16'h0002, 1'b1, 8'h00, 1'b1);
    add(16'h0003, 1'b1, 8'h00, 1'b1); idle(5);
    add(16'h0020, 1'b0, 8'h5A, 1'b1);
    add(16'h0020, 1'b1, 8'h00, 1'b1); idle(4);
    add(16'h00F5, 1'b0, 8'h55, 1'b1);
    add(16'h00F5, 1'b1, 8'h00, 1'b1); idle(4);
    add(16'h0000, 1'b1, 8'h00, 1'b1); idle(4);

    #2;
    reset_pulse();

    foreach (vecs[i]) step(vecs[i].a, vecs[i].r, vecs[i].wd, vecs[i].exp_hit);

    // Reset two cycles into a read, then the same read must stall in full again.
    step(16'h0010, 1'b1, 8'h00, 1'b1);
    step(16'h0100, 1'b1, 8'h00, 1'b0);
    reset_pulse();
    step(16'h0010, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(16'h0100, 1'b1, 8'h00, 1'b0);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads: got %0d outstanding want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side responder for the 6502C external bus: decodes extAB, serves reads from and takes writes into an internal RAM window, and drives the data bus toward the CPU.
- Throttles slow reads by deasserting RDY for a programmable number of wait states.
- Replaces the zero-latency behavioural memory in CPU benches, so CPU RDY handling gets exercised.

Parameters:
- BASE_ADDR, 16'h0000, first CPU address of the window; must be aligned to 2^ADDR_BITS.
- ADDR_BITS, 8, window size is 2^ADDR_BITS bytes; valid range 4..12.
- WAIT_STATES, 1, RDY-low cycles inserted per read; valid range 0..15.
- RO_LO, 8'hF0, first window offset of the write-protected region.
- RO_HI, 8'hFF, last window offset of the write-protected region, inclusive. RO_LO > RO_HI means no protection.

Ports:
- clock  in  1  single bus clock; all state changes on rising edge.
- RES_L  in  1  asynchronous active-low reset.
- ab  in  16  CPU address bus (extAB).
- db_in  in  8  CPU write data (extDB when RW=0).
- rw  in  1  1 = read, 0 = write.
- db_out  out  8  read data toward CPU.
- db_oe  out  1  1 = db_out must drive extDB; the top-level tristate uses this.
- rdy  out  1  to CPU RDY; 0 = stall.
- hit  out  1  combinational: ab is inside the window.
- wp_err  out  1  one-cycle pulse on a blocked write.

Behaviour:
- Decode: hit = (ab[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]). offset = ab[ADDR_BITS-1:0].
- Reset, asynchronous on RES_L low and immediate:
  - state=IDLE, rdy=1, db_oe=0, db_out=8'h00, wp_err=0, wait counter=0, latched offset=0.
  - RAM contents are not cleared.
  - Reset mid-wait abandons the read; after RES_L rises, the next edge samples a fresh request.
- FSM states:
  - IDLE: no read outstanding.
  - WAIT: counting wait states.
  - DATA: presenting read data.
- Acceptance: a request is sampled at a rising edge in IDLE or DATA state.
  - Read accept (hit=1, rw=1): latch offset.
    - WAIT_STATES=0 -> DATA.
    - Otherwise -> WAIT with counter=WAIT_STATES, and rdy=0 from that edge.
  - Write accept (hit=1, rw=0):
    - offset outside [RO_LO,RO_HI]: RAM[offset] <= db_in at that edge.
    - offset inside the range: RAM unchanged, wp_err=1 for the following cycle.
    - Writes never stall (rdy stays 1) and always go to IDLE; db_oe=0.
  - Miss (hit=0): -> IDLE; rdy=1, db_oe=0 (open bus).
- WAIT:
  - Counter decrements each edge. When the counter reaches 1, next state is DATA and rdy returns to 1.
  - rdy is therefore low for exactly WAIT_STATES cycles.
  - ab/rw are ignored in WAIT; the latched offset is used even if the CPU changes ab (protocol violation, not an error).
- DATA:
  - For exactly one cycle: db_out = RAM[latched offset], registered, db_oe=1, rdy=1.
  - A new request sampled at the edge leaving DATA is accepted normally, so back-to-back reads with WAIT_STATES=0 give data every cycle.
- Read latency: data is valid in cycle k+1+WAIT_STATES for a read sampled at edge k.
- Write-then-read to the same offset on consecutive edges returns the new value; the RAM write completes before the read access.
- db_out holds its last value when db_oe=0. Consumers must gate on db_oe.
- wp_err is high only for the cycle after the blocked write edge and is never sticky.

Test Plan:
1. Reset: assert RES_L low two cycles into a WAIT_STATES=3 read -> rdy=1, db_oe=0, db_out=00 with no clock edge. After release, read 0x0010 -> the full 3 wait states are inserted again.
2. WAIT_STATES=2: write 0x3C to 0x0010, then read 0x0010 -> rdy=0 for exactly 2 cycles, then db_out=3C with db_oe=1 for 1 cycle, then db_oe=0.
3. Write 0xAA to 0x00F5 after it holds 0x11 -> wp_err=1 for one cycle; a subsequent read of 0x00F5 returns 11. A write to 0x00EF succeeds.
4. Read 0x0100 (BASE 0000, ADDR_BITS 8) -> hit=0, rdy=1, db_oe=0, and the FSM stays IDLE.
5. WAIT_STATES=0: reads of 0x0000..0x0003 on consecutive edges (preloaded 01,02,03,04) -> db_out=01,02,03,04 on four consecutive cycles, db_oe=1 throughout, rdy never 0.
6. Write 0x5A to 0x0020 at edge k, read 0x0020 sampled at edge k+1 (WAIT_STATES=1) -> rdy=0 for one cycle, then db_out=5A.
